// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI transaction sequencer.
package spi_pkg;

  // Width of the bytes exchanged with the single-byte SPI engine.
  localparam int SPI_BYTE_W = 8;

  // Sequencer states; the encoding is also exported on dbg_state.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_XFER  = 3'd3,
    ST_GAP   = 3'd4,
    ST_HOLD  = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // The timer reports zero on its last counted cycle, so a phase of
  // n cycles loads n-1. A zero-length phase is never entered.
  function automatic int tmr_load_val(input int n);
    return (n > 0) ? n - 1 : 0;
  endfunction

endpackage

// File: rtl/spi_txn_timer.sv
// Down-counter shared by the SETUP, GAP and HOLD phases.
// load has priority; zero is high once the count has run out.
module spi_txn_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             zero
);

  logic [TMR_W-1:0] cnt;

  // Load a new phase length or count down, saturating at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TMR_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/spi_txn_ctrl.sv
// Multi-byte SPI transaction sequencer: owns chip select and its
// setup/hold/inter-byte timing, feeds tx bytes to the byte engine and
// returns each rx byte.
//
// Handshakes: a command is accepted on a cycle where cmd_valid and
// cmd_ready are both high. A tx byte is consumed on a cycle where
// tx_valid and tx_ready are both high (tx_ready is a combinational
// pulse that coincides with spi_start). rx_valid, done and spi_start
// are single-cycle pulses with no backpressure.
module spi_txn_ctrl
  import spi_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int CS_SETUP = 4,
  parameter int BYTE_GAP = 2,
  parameter int CS_HOLD  = 4,
  parameter int TMR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             done,
  output logic             busy,
  output logic             cs_n,
  output logic             spi_start,
  output logic [7:0]       spi_data_in,
  input  logic             spi_busy,
  input  logic             spi_new_data,
  input  logic [7:0]       spi_data_out,
  output logic [2:0]       dbg_state
);

  localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(tmr_load_val(CS_SETUP));
  localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(tmr_load_val(BYTE_GAP));
  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(tmr_load_val(CS_HOLD));

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             abort_q;
  logic             abort_seen;
  logic             accept;
  logic             load_fire;
  logic             last_byte;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  // An abort pulse acts in the cycle it arrives as well as afterwards.
  assign abort_seen = abort_q | abort;
  assign accept     = cmd_valid & cmd_ready;
  assign last_byte  = (remaining == LEN_W'(1));

  // A byte is launched only from LOAD, with data present, engine idle
  // and no abort pending.
  assign load_fire   = (state == ST_LOAD) & tx_valid & ~spi_busy & ~abort_seen;
  assign tx_ready    = load_fire;
  assign spi_start   = load_fire;
  assign spi_data_in = (state == ST_LOAD) ? tx_data : 8'h00;
  assign dbg_state   = state;

  // Pick the phase length to load on the transition into a timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (accept && cmd_len != '0) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_SETUP, ST_LOAD, ST_GAP: begin
        if (abort_seen) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      ST_XFER: begin
        if (spi_new_data) begin
          if (last_byte || abort_seen) begin
            tmr_load = 1'b1;
            tmr_val  = HOLD_LD;
          end else if (BYTE_GAP != 0) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LD;
          end
        end
      end
      default: begin
        tmr_load = 1'b0;
        tmr_val  = '0;
      end
    endcase
  end

  spi_txn_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Transaction FSM with registered chip select, status and rx outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      abort_q   <= 1'b0;
      cs_n      <= 1'b1;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rx_valid  <= 1'b0;
      rx_data   <= 8'h00;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      if (state != ST_IDLE && state != ST_DONE && abort) begin
        abort_q <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_len != '0) begin
              remaining <= cmd_len;
              cs_n      <= 1'b0;
              state     <= ST_SETUP;
            end else begin
              // Empty transaction: report completion without touching cs_n.
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_SETUP: begin
          if (abort_seen) begin
            state <= ST_HOLD;
          end else if (tmr_zero) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (abort_seen) begin
            state <= ST_HOLD;
          end else if (load_fire) begin
            state <= ST_XFER;
          end
        end
        ST_XFER: begin
          // Completion is taken from the engine's pulse, never from busy.
          if (spi_new_data) begin
            rx_data   <= spi_data_out;
            rx_valid  <= 1'b1;
            remaining <= remaining - LEN_W'(1);
            if (last_byte || abort_seen) begin
              state <= ST_HOLD;
            end else if (BYTE_GAP == 0) begin
              state <= ST_LOAD;
            end else begin
              state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (abort_seen) begin
            state <= ST_HOLD;
          end else if (tmr_zero) begin
            state <= ST_LOAD;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) begin
            cs_n  <= 1'b1;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          abort_q   <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_ctrl.sv
// Bench for spi_txn_ctrl: behavioural byte engine, driver task, and a
// scoreboard that pops expected rx bytes / transaction summaries.
module tb_spi_txn_ctrl;

  localparam int LEN_W    = 8;
  localparam int CS_SETUP = 4;
  localparam int BYTE_GAP = 2;
  localparam int CS_HOLD  = 4;
  localparam int ENG      = 6;        // engine busy cycles per byte
  localparam int XFER_CYC = ENG + 2;  // spi_start cycle to spi_new_data cycle, inclusive
  localparam int LIMIT    = 3000;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             abort;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             done;
  logic             busy;
  logic             cs_n;
  logic             spi_start;
  logic [7:0]       spi_data_in;
  logic             spi_busy;
  logic             spi_new_data;
  logic [7:0]       spi_data_out;
  logic [2:0]       dbg_state;

  spi_txn_ctrl #(
    .LEN_W    (LEN_W),
    .CS_SETUP (CS_SETUP),
    .BYTE_GAP (BYTE_GAP),
    .CS_HOLD  (CS_HOLD),
    .TMR_W    (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_len      (cmd_len),
    .abort        (abort),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .done         (done),
    .busy         (busy),
    .cs_n         (cs_n),
    .spi_start    (spi_start),
    .spi_data_in  (spi_data_in),
    .spi_busy     (spi_busy),
    .spi_new_data (spi_new_data),
    .spi_data_out (spi_data_out),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    int n_bytes;
    int cs_low;   // -1 when the transaction had stalls and timing is not predicted
  } done_exp_t;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  done_exp_t  exp_done[$];

  int n_chk     = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  int done_cnt  = 0;
  int resp_force = -1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural byte engine ----------------
  // Drives on the falling edge, samples 1 time unit later.
  logic       eng_start_seen = 1'b0;
  logic       eng_rst_seen   = 1'b0;
  int         eng_cnt        = 0;
  logic [7:0] eng_resp;

  always @(negedge clk) begin
    spi_new_data = 1'b0;
    if (eng_rst_seen) begin
      eng_cnt  = 0;
      spi_busy = 1'b0;
    end else if (eng_start_seen) begin
      spi_busy = 1'b1;
      eng_cnt  = ENG;
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_resp     = (resp_force >= 0) ? 8'(resp_force) : 8'($urandom_range(0, 255));
        spi_busy     = 1'b0;
        spi_new_data = 1'b1;
        spi_data_out = eng_resp;
        exp_rx.push_back(eng_resp);
      end
    end
    #1;
    eng_rst_seen   = rst;
    eng_start_seen = spi_start && !rst;
    if (spi_start && !rst) begin
      start_cnt++;
      chk("start_while_engine_busy", int'(spi_busy), 0);
      chk("start_without_tx_valid", int'(tx_valid), 1);
      if (exp_tx.size() == 0) begin
        chk("unexpected_spi_start", 1, 0);
      end else begin
        chk("spi_data_in", int'(spi_data_in), int'(exp_tx.pop_front()));
      end
    end
  end

  // ---------------- output monitor ----------------
  int mon_rx = 0;
  int mon_cs = 0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      mon_rx = 0;
      mon_cs = 0;
      exp_rx.delete();
    end else begin
      if (cs_n == 1'b0) mon_cs++;
      if (rx_valid) begin
        mon_rx++;
        if (exp_rx.size() == 0) chk("unexpected_rx_valid", 1, 0);
        else chk("rx_data", int'(rx_data), int'(exp_rx.pop_front()));
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          done_exp_t e;
          e = exp_done.pop_front();
          chk("rx_bytes_per_txn", mon_rx, e.n_bytes);
          if (e.cs_low >= 0) chk("cs_n_low_cycles", mon_cs, e.cs_low);
        end
        mon_rx = 0;
        mon_cs = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // mode: 0 normal, 1 abort during SETUP, 2 abort during byte 2, 3 rst during byte 1
  // pat:  0 random bytes, 1 single 8'hA5, 2 incrementing 1,2,3...
  task automatic run_txn(input int len, input int mode, input int stall_cyc,
                         input bit rand_stall, input int pat);
    logic [7:0] tx[$];
    int n_exp, cs_exp, base, i, stall, cyc, cs_cnt, ab_t, r_t, done_at, w;
    bit fin, cs_bad, rst_hit;
    done_exp_t e;

    for (int k = 0; k < len; k++) begin
      if (pat == 1) tx.push_back(8'hA5);
      else if (pat == 2) tx.push_back(8'(k + 1));
      else tx.push_back(8'($urandom_range(0, 255)));
    end
    n_exp = (mode == 1) ? 0 : (mode == 2) ? 2 : (mode == 3) ? 1 : len;
    for (int k = 0; k < n_exp; k++) exp_tx.push_back(tx[k]);
    if (stall_cyc > 0 || rand_stall) cs_exp = -1;
    else if (mode == 1) cs_exp = CS_HOLD + 2;
    else if (n_exp == 0) cs_exp = 0;
    else cs_exp = CS_SETUP + n_exp * XFER_CYC + (n_exp - 1) * BYTE_GAP + CS_HOLD;
    e.n_bytes = n_exp;
    e.cs_low  = cs_exp;
    if (mode != 3) exp_done.push_back(e);

    // wait for the sequencer to be idle
    w = 0;
    do begin
      @(negedge clk);
      #1;
      w++;
    end while (!cmd_ready && w < 200);
    chk("idle_before_cmd", int'(cmd_ready), 1);

    base = start_cnt;
    i = 0; stall = 0; cyc = 0; cs_cnt = 0; ab_t = 0; r_t = 0; done_at = -1;
    fin = 0; cs_bad = 0; rst_hit = 0;
    while (!fin && cyc < LIMIT) begin
      if (rst_hit) begin
        rst = 1'b0;
        tx_valid = 1'b0;
        #1;
        chk("cs_n_after_rst", int'(cs_n), 1);
        chk("cmd_ready_after_rst", int'(cmd_ready), 1);
        chk("busy_after_rst", int'(busy), 0);
        fin = 1;
      end else begin
        cmd_valid = (cyc == 0);
        cmd_len   = LEN_W'(len);
        tx_valid  = 1'b0;
        if (i < len) begin
          if (i == 1 && stall < stall_cyc) begin
            stall++;
          end else if (!(rand_stall && $urandom_range(0, 3) == 0)) begin
            tx_valid = 1'b1;
            tx_data  = tx[i];
          end
        end
        abort = (mode == 1 && cs_cnt == 1) || (mode == 2 && ab_t == 2);
        rst   = (mode == 3 && r_t == 3);
        #1;
        if (tx_valid && tx_ready) i++;
        if (i == 1 && stall > 0 && stall <= stall_cyc && cs_n != 1'b0) cs_bad = 1;
        if (cs_n == 1'b0) cs_cnt++;
        if (mode == 2 && start_cnt - base >= 2 && ab_t < 3) ab_t++;
        if (mode == 3 && start_cnt - base >= 1 && r_t < 4) r_t++;
        if (rst) rst_hit = 1;
        if (done) begin
          fin = 1;
          done_at = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end
    cmd_valid = 1'b0;
    tx_valid  = 1'b0;
    abort     = 1'b0;
    rst       = 1'b0;
    chk("txn_completed_in_budget", int'(fin), 1);
    if (mode != 3) begin
      #1;
      chk("cmd_ready_after_done", int'(cmd_ready), 1);
    end
    if (len == 0) chk("len0_done_latency", done_at, 1);
    if (stall_cyc > 0) chk("cs_n_held_during_stall", int'(cs_bad), 0);
    chk("spi_start_count", start_cnt - base, n_exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; abort = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    spi_busy = 1'b0; spi_new_data = 1'b0; spi_data_out = 8'h00;
    repeat (4) @(negedge clk);
    #1;
    chk("reset_cs_n", int'(cs_n), 1);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_spi_start", int'(spi_start), 0);
    chk("reset_tx_ready", int'(tx_ready), 0);
    @(negedge clk);
    rst = 1'b0;

    // single byte, fixed data and echo
    resp_force = 8'h3C;
    run_txn(1, 0, 0, 0, 1);
    resp_force = -1;
    // three bytes, always valid
    run_txn(3, 0, 0, 0, 2);
    // tx_valid dropped for 20 cycles before byte 2
    run_txn(2, 0, 20, 0, 0);
    // abort mid byte 2, then abort during SETUP
    run_txn(4, 2, 0, 0, 0);
    run_txn(4, 1, 0, 0, 0);
    // empty transaction
    run_txn(0, 0, 0, 0, 0);
    // reset during the first byte, then a fresh transaction
    run_txn(3, 3, 0, 0, 0);
    repeat (20) @(negedge clk);
    run_txn(2, 0, 0, 0, 0);
    // randomized lengths, with and without tx stalls
    for (int t = 0; t < 12; t++) begin
      run_txn($urandom_range(1, 6), 0, 0, bit'(t % 2), 0);
    end
    repeat (10) @(negedge clk);
    #2;
    chk("leftover_expected_tx", exp_tx.size(), 0);
    chk("leftover_expected_rx", exp_rx.size(), 0);
    chk("leftover_expected_done", exp_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
